// File: rtl/cordic_arbiter.sv
// Two-requester front end for a fixed-latency CORDIC pipeline: round-robin issue,
// tag tracking alongside the pipeline, per-requester response FIFOs and credit flow control.
module cordic_arbiter #(
  parameter int INPUT_WIDTH      = 16,
  parameter int OUTPUT_WIDTH     = 16,
  parameter int ITERATION_NUMBER = 6,
  parameter int DEPTH            = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [INPUT_WIDTH-1:0]  req0_x,
  input  logic [INPUT_WIDTH-1:0]  req0_y,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [INPUT_WIDTH-1:0]  req1_x,
  input  logic [INPUT_WIDTH-1:0]  req1_y,
  output logic                    req1_ready,
  output logic                    pipe_valid_out,
  output logic [INPUT_WIDTH-1:0]  pipe_x,
  output logic [INPUT_WIDTH-1:0]  pipe_y,
  input  logic                    pipe_valid_in,
  input  logic [OUTPUT_WIDTH-1:0] pipe_result,
  output logic                    rsp0_valid,
  output logic [OUTPUT_WIDTH-1:0] rsp0_data,
  input  logic                    rsp0_ready,
  output logic                    rsp1_valid,
  output logic [OUTPUT_WIDTH-1:0] rsp1_data,
  input  logic                    rsp1_ready,
  output logic                    err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  logic                    r_last_grant;
  logic [CW-1:0]           r_credit [2];
  logic                    r_pipe_valid;
  logic                    r_pipe_id;
  logic [INPUT_WIDTH-1:0]  r_pipe_x;
  logic [INPUT_WIDTH-1:0]  r_pipe_y;
  logic [ITERATION_NUMBER-1:0] r_tag_valid;
  logic [ITERATION_NUMBER-1:0] r_tag_id;
  logic [OUTPUT_WIDTH-1:0] r_mem [2][DEPTH];
  logic [PW-1:0]           r_wptr [2];
  logic [PW-1:0]           r_rptr [2];
  logic [CW-1:0]           r_count [2];
  logic                    r_err;

  logic [1:0] w_req_valid, w_rsp_ready, w_elig, w_grant, w_wr, w_pop, w_full, w_nonempty;
  logic       w_tag_valid, w_tag_id, w_err_evt;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_elig[n]     = !rst && w_req_valid[n] && (r_credit[n] != '0);
      w_full[n]     = (r_count[n] == CREDIT_MAX);
      w_nonempty[n] = !rst && (r_count[n] != '0);
    end
  end

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    w_grant = 2'b00;
    if (w_elig[0] && w_elig[1]) w_grant = r_last_grant ? 2'b01 : 2'b10;
    else if (w_elig[0])         w_grant = 2'b01;
    else if (w_elig[1])         w_grant = 2'b10;
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  assign w_tag_valid = r_tag_valid[ITERATION_NUMBER-1];
  assign w_tag_id    = r_tag_id[ITERATION_NUMBER-1];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_wr[n]  = !rst && pipe_valid_in && w_tag_valid && (w_tag_id == n[0]) && !w_full[n];
      w_pop[n] = w_nonempty[n] && w_rsp_ready[n];
    end
  end

  // Orphan results, missing results and writes into a full FIFO are all unrecoverable.
  assign w_err_evt = (pipe_valid_in != w_tag_valid) ||
                     (pipe_valid_in && w_tag_valid && w_full[w_tag_id]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_valid <= 1'b0;
      r_pipe_id    <= 1'b0;
      r_pipe_x     <= '0;
      r_pipe_y     <= '0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      r_pipe_valid <= |w_grant;
      if (w_grant[0]) begin
        r_pipe_x <= req0_x;
        r_pipe_y <= req0_y;
      end else if (w_grant[1]) begin
        r_pipe_x <= req1_x;
        r_pipe_y <= req1_y;
      end
      if (|w_grant) begin
        r_pipe_id    <= w_grant[1];
        r_last_grant <= w_grant[1];
      end
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  // Tag stage 0 follows the issue register, so the last stage lines up with pipe_valid_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_valid <= '0;
      r_tag_id    <= '0;
    end else begin
      r_tag_valid[0] <= r_pipe_valid;
      r_tag_id[0]    <= r_pipe_id;
      for (int k = 1; k < ITERATION_NUMBER; k++) begin
        r_tag_valid[k] <= r_tag_valid[k-1];
        r_tag_id[k]    <= r_tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        r_wptr[n]   <= '0;
        r_rptr[n]   <= '0;
        r_count[n]  <= '0;
        r_credit[n] <= CREDIT_MAX;
      end else begin
        if (w_wr[n])  r_wptr[n] <= (r_wptr[n] == PTR_LAST) ? '0 : r_wptr[n] + 1'b1;
        if (w_pop[n]) r_rptr[n] <= (r_rptr[n] == PTR_LAST) ? '0 : r_rptr[n] + 1'b1;
        r_count[n]  <= r_count[n] + CW'(w_wr[n]) - CW'(w_pop[n]);
        r_credit[n] <= r_credit[n] - CW'(w_grant[n]) + CW'(w_pop[n]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_wr[n]) r_mem[n][r_wptr[n]] <= pipe_result;
    end
  end

  assign pipe_valid_out = r_pipe_valid;
  assign pipe_x         = r_pipe_x;
  assign pipe_y         = r_pipe_y;
  assign rsp0_valid     = w_nonempty[0];
  assign rsp1_valid     = w_nonempty[1];
  assign rsp0_data      = r_mem[0][r_rptr[0]];
  assign rsp1_data      = r_mem[1][r_rptr[1]];
  assign err            = r_err;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: a behavioural 6-stage pipeline returns
// x + 3*y + 0xAACD, and every check compares against a hand-computed constant.
module tb_cordic_arbiter;
  localparam int N = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        req0_ready, req1_ready;
  logic        pipe_valid_out, pipe_valid_in;
  logic [15:0] pipe_x, pipe_y, pipe_result;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_data, rsp1_data;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        err;

  logic        man_v = 1'b0;
  logic [15:0] man_d = '0;
  logic [N-1:0] mdl_v = '0;
  logic [15:0] mdl_d [N];

  int n_checks = 0;
  int n_fail   = 0;

  cordic_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .pipe_valid_out(pipe_valid_out), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .pipe_valid_in(pipe_valid_in), .pipe_result(pipe_result),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cordic_model(input logic [15:0] x, input logic [15:0] y);
    return x + 16'(3 * y) + 16'hAACD;
  endfunction

  // Stand-in for the CORDIC pipeline; deliberately not reset so stale results survive rst.
  always @(posedge clk) begin
    mdl_v    <= {mdl_v[N-2:0], pipe_valid_out};
    mdl_d[0] <= cordic_model(pipe_x, pipe_y);
    for (int k = 1; k < N; k++) mdl_d[k] <= mdl_d[k-1];
  end

  assign pipe_valid_in = mdl_v[N-1] | man_v;
  assign pipe_result   = man_v ? man_d : mdl_d[N-1];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and ready suppression during reset
    step(2);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_pipe_valid", 32'(pipe_valid_out), 0);
    chk("rst_pipe_x", 32'(pipe_x), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_err", 32'(err), 0);
    req1_valid = 1'b0;

    // Single request: accept at edge 0, response visible in cycle 8
    rst = 1'b0; req0_x = 16'h0100; req0_y = 16'h0000;
    #1;
    chk("single_ready0", 32'(req0_ready), 1);
    chk("single_ready1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    chk("single_pvo_c1", 32'(pipe_valid_out), 1);
    chk("single_px_c1", 32'(pipe_x), 32'h0100);
    chk("single_py_c1", 32'(pipe_y), 32'h0000);
    step();
    chk("single_pvo_c2", 32'(pipe_valid_out), 0);
    chk("single_px_hold", 32'(pipe_x), 32'h0100);
    step(5);
    chk("single_rsp0_c7", 32'(rsp0_valid), 0);
    step();
    chk("single_rsp0_c8", 32'(rsp0_valid), 1);
    chk("single_data_c8", 32'(rsp0_data), 32'hABCD);
    chk("single_rsp1_c8", 32'(rsp1_valid), 0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("single_popped", 32'(rsp0_valid), 0);

    // Contention after reset: grants alternate 0,1,0,1
    rst = 1'b1; step(); rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_x = 16'h1000 + 16'(k); req0_y = 16'(k);
      req1_x = 16'h2000 + 16'(k); req1_y = 16'h0010 + 16'(k);
      #1;
      chk("cont_ready0", 32'(req0_ready), 32'((k % 2) == 0));
      chk("cont_ready1", 32'(req1_ready), 32'((k % 2) == 1));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(8);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    chk("cont_rsp0_a", 32'(rsp0_data), 32'hBACD);
    chk("cont_rsp1_a", 32'(rsp1_data), 32'hCB01);
    step();
    chk("cont_rsp0_b_v", 32'(rsp0_valid), 1);
    chk("cont_rsp0_b", 32'(rsp0_data), 32'hBAD5);
    chk("cont_rsp1_b_v", 32'(rsp1_valid), 1);
    chk("cont_rsp1_b", 32'(rsp1_data), 32'hCB09);
    step();
    chk("cont_rsp0_empty", 32'(rsp0_valid), 0);
    chk("cont_rsp1_empty", 32'(rsp1_valid), 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Credit stall on requester 1
    req1_valid = 1'b1; req1_y = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      req1_x = 16'h3000 + 16'(k);
      #1;
      chk("stall_ready1", 32'(req1_ready), 32'(k < 4));
      chk("stall_ready0", 32'(req0_ready), 0);
      step();
    end
    step(8);
    chk("stall_full_ready1", 32'(req1_ready), 0);
    chk("stall_rsp1_v", 32'(rsp1_valid), 1);
    chk("stall_rsp1_d", 32'(rsp1_data), 32'hDACD);
    rsp1_ready = 1'b1; req1_x = 16'h3100;
    step();
    rsp1_ready = 1'b0;
    chk("stall_one_credit", 32'(req1_ready), 1);
    step();
    chk("stall_again", 32'(req1_ready), 0);
    req1_valid = 1'b0;
    step(8);
    rsp1_ready = 1'b1;
    chk("stall_drain0", 32'(rsp1_data), 32'hDACE);
    step();
    chk("stall_drain1", 32'(rsp1_data), 32'hDACF);
    step();
    chk("stall_drain2", 32'(rsp1_data), 32'hDAD0);
    step();
    chk("stall_drain3_v", 32'(rsp1_valid), 1);
    chk("stall_drain3", 32'(rsp1_data), 32'hDBCD);
    step();
    chk("stall_drain_empty", 32'(rsp1_valid), 0);
    rsp1_ready = 1'b0;

    // Accept and pop on the same edge leave credit_0 unchanged
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h0000;
    #1;
    chk("simul_a_ready", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    step(7);
    chk("simul_a_rsp_v", 32'(rsp0_valid), 1);
    chk("simul_a_rsp_d", 32'(rsp0_data), 32'hEACD);
    req0_valid = 1'b1; req0_x = 16'h4001; rsp0_ready = 1'b1;
    #1;
    chk("simul_b_ready", 32'(req0_ready), 1);
    step();
    rsp0_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req0_x = 16'h4002 + 16'(k);
      #1;
      chk("simul_credit3", 32'(req0_ready), 32'(k < 3));
      step();
    end
    req0_valid = 1'b0;
    step(9);
    rsp0_ready = 1'b1;
    chk("simul_drain0", 32'(rsp0_data), 32'hEACE);
    step();
    chk("simul_drain1", 32'(rsp0_data), 32'hEACF);
    step();
    chk("simul_drain2", 32'(rsp0_data), 32'hEAD0);
    step();
    chk("simul_drain3", 32'(rsp0_data), 32'hEAD1);
    step();
    chk("simul_drain_empty", 32'(rsp0_valid), 0);
    rsp0_ready = 1'b0;

    // FIFO0 write and pop on the same edge keep occupancy at one
    req0_valid = 1'b1; req0_x = 16'h5000;
    step();
    req0_x = 16'h5001;
    step();
    req0_valid = 1'b0;
    step(6);
    chk("wp_first_v", 32'(rsp0_valid), 1);
    chk("wp_first_d", 32'(rsp0_data), 32'hFACD);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("wp_second_v", 32'(rsp0_valid), 1);
    chk("wp_second_d", 32'(rsp0_data), 32'hFACE);
    step();
    chk("wp_occ_one", 32'(rsp0_valid), 1);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("wp_occ_zero", 32'(rsp0_valid), 0);
    chk("wp_no_err", 32'(err), 0);

    // Unexpected pipe_valid_in sets sticky err and drops the result
    man_v = 1'b1; man_d = 16'h1234;
    #1;
    chk("err_before", 32'(err), 0);
    step();
    man_v = 1'b0;
    chk("err_set", 32'(err), 1);
    step(3);
    chk("err_sticky", 32'(err), 1);
    chk("err_drop0", 32'(rsp0_valid), 0);
    chk("err_drop1", 32'(rsp1_valid), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", 32'(err), 0);

    // Reset with three results in flight
    req0_valid = 1'b1; req0_y = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      req0_x = 16'h6000 + 16'(k);
      #1;
      chk("flight_ready", 32'(req0_ready), 1);
      step();
    end
    req0_valid = 1'b0;
    step();
    rst = 1'b1; req0_valid = 1'b1;
    #1;
    chk("flight_rst_ready", 32'(req0_ready), 0);
    step();
    rst = 1'b0; req0_valid = 1'b0;
    chk("flight_post_err", 32'(err), 0);
    chk("flight_post_rsp", 32'(rsp0_valid), 0);
    step(2);
    chk("flight_err_c7", 32'(err), 0);
    step();
    chk("flight_err_c8", 32'(err), 1);
    chk("flight_rsp_c8", 32'(rsp0_valid), 0);
    step(2);
    chk("flight_rsp_c10", 32'(rsp0_valid), 0);
    req0_valid = 1'b1; req0_x = 16'h7000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("flight_credits", 32'(req0_ready), 32'(k < 4));
      step();
    end
    req0_valid = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16, operand width of x/y.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 16, result width.
REQ-003 SHALL have parameter ITERATION_NUMBER, default 6, fixed pipeline latency in cycles from pipe_valid_out to pipe_valid_in.
REQ-004 SHALL have parameter DEPTH, default 4, per-requester response FIFO depth and credit limit.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-006 Ports for requester n in {0,1}: reqn_valid (in, 1), reqn_x (in, INPUT_WIDTH), reqn_y (in, INPUT_WIDTH), reqn_ready (out, 1, request handshake).
REQ-007 Ports: pipe_valid_out (out, 1), pipe_x (out, INPUT_WIDTH), pipe_y (out, INPUT_WIDTH), the operand issue to the CORDIC pipeline.
REQ-008 Ports: pipe_valid_in (in, 1) and pipe_result (in, OUTPUT_WIDTH), the pipeline result, which cannot be stalled.
REQ-009 Ports for requester n: rspn_valid (out, 1), rspn_data (out, OUTPUT_WIDTH), rspn_ready (in, 1, response handshake).
REQ-010 Port: err (out, 1), sticky error flag.

Function
REQ-011 Each requester SHALL have a credit counter, range 0..DEPTH, that counts DEPTH minus (in-flight plus buffered) results.
REQ-012 Requester n is eligible when reqn_valid=1 and credit_n>0.
REQ-013 Arbitration SHALL be combinational round-robin with a last_grant register:
- one eligible requester is granted;
- both eligible grants the requester not equal to last_grant;
- none eligible grants nothing.
REQ-014 reqn_ready SHALL equal grant_n; at most one ready is high per cycle; ready SHALL NOT depend on rspn_ready.
REQ-015 On an accepted request (valid and ready at edge t), the block SHALL register the operands so that pipe_valid_out=1 with pipe_x/pipe_y held in cycle t+1; otherwise pipe_valid_out=0 and pipe_x/pipe_y hold their previous values.
REQ-016 On accept, last_grant SHALL become n and credit_n SHALL decrement.
REQ-017 A tag shift register, ITERATION_NUMBER stages of {valid, id}, SHALL be loaded alongside pipe_valid_out so that its output aligns with pipe_valid_in.
REQ-018 When pipe_valid_in=1 and the tag output is valid, pipe_result SHALL be written into FIFO[id].
REQ-019 rspn_valid SHALL be high whenever FIFOn is non-empty, with rspn_data showing the head entry; the earliest rsp is ITERATION_NUMBER+2 cycles after the request accept edge.
REQ-020 A response handshake pops FIFOn and increments credit_n.
REQ-021 Accept and pop on the same edge SHALL leave credit_n unchanged.
REQ-022 FIFO write and pop on the same edge SHALL leave occupancy unchanged, and SHALL be correct including when the FIFO is empty-then-written.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; the credit scheme guarantees no overflow.
REQ-024 Any write into a full FIFO SHALL set err and drop the data.
REQ-025 err SHALL be set, and the result dropped, when:
- pipe_valid_in=1 while the tag output is invalid; or
- pipe_valid_in=0 while the tag output is valid.
REQ-026 Results SHALL be returned in per-requester issue order.
REQ-027 Results SHALL NOT be routed to the non-issuing requester.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL clear:
- pipe_valid_out, pipe_x, pipe_y to 0;
- all tag stages to 0;
- both FIFOs to empty;
- credits to DEPTH;
- last_grant to 1, so requester 0 wins the first tie;
- err to 0.
REQ-029 During rst=1, reqn_ready SHALL be 0 and rspn_valid SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered results.
REQ-031 Results still emerging from the pipeline after reset SHALL flag err.

Verification
REQ-032 Single request: req0 x=0x0100, y=0x0000 accepted at edge 0 -> pipe_valid_out in cycle 1; pipe_result=0xABCD returned in cycle 7; rsp0_valid=1 with rsp0_data=0xABCD in cycle 8.
REQ-033 Contention: both requesters valid every cycle after reset -> grants alternate 0,1,0,1; each requester's responses arrive in its issue order.
REQ-034 Credit stall: rsp1_ready=0 and req1 valid every cycle -> exactly 4 req1 accepts, then req1_ready=0; one rsp1 pop re-enables exactly 1 accept.
REQ-035 Simultaneous events: a req0 accept and rsp0 pop on the same edge leave credit_0 unchanged; a FIFO0 write and pop on the same edge leave FIFO0 occupancy unchanged.
REQ-036 Error: drive pipe_valid_in=1 with no prior issue -> err=1 in the next cycle, remaining set until rst.
REQ-037 Reset with 3 results in flight -> post-reset rsp0_valid=0, credits=DEPTH, err=1 when the stale pipe_valid_in arrives.
